image_load_ctrl: RTL and testbench

- Sequences a full-frame image download from the UART image loader into the shared pixel SRAM.
- Accepts the loader's 24-bit RGB888 pixel stream, which has no backpressure, and buffers it in a small FIFO.
- Converts each pixel to RGB565 and issues one SRAM write per pixel, only in cycles where the SRAM arbiter grants the port.
- Counts pixels to frame size and signals completion so the display path can swap to the new frame.

---
 rtl/image_pkg.sv | 24 ++
 rtl/image_load_ctrl_fifo.sv | 54 +++++
 rtl/image_load_ctrl.sv | 118 +++++++++++
 tb/tb_image_load_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and helpers for the frame-load path: FSM states, frame size, RGB888 to RGB565 packing.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IMG_W_DEF    = 640;
  localparam int IMG_H_DEF    = 480;
  localparam int FRAME_PIXELS = IMG_W_DEF * IMG_H_DEF;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

  // Keep the top bits of each channel: {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

endpackage

// File: rtl/image_load_ctrl_fifo.sv
// Synchronous pixel FIFO with registered pointers and a combinational head.
// Latency: a push is visible at the head (empty low) the cycle after it is written.
// Backpressure: none internally; push while full is dropped unless a pop occurs in the same cycle.
module pix_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/image_load_ctrl.sv
// Frame loader: buffers the UART pixel stream and writes RGB565 words to the shared SRAM.
// Latency: a pixel pushed into an empty FIFO during LOAD is requested on the next cycle.
// Backpressure: loader stream cannot stall; FIFO overrun drops the pixel and sets a sticky overflow.
module image_load_ctrl
  import image_pkg::*;
#(
  parameter int                IMG_W      = IMG_W_DEF,
  parameter int                IMG_H      = IMG_H_DEF,
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              i_start,
  input  logic [23:0]       i_pix_data,
  input  logic              i_pix_valid,
  output logic              o_sram_req,
  input  logic              i_sram_grant,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W-1:0] o_pix_count
);

  localparam int                FRAME     = frame_pixels(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W+1)'(FRAME);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pix_count;
  logic [ADDR_W:0]   push_cnt;
  logic              overflow_r;
  logic              done_r;

  logic              start_acc;
  logic              accepting;
  logic              push_try;
  logic              push_ok;
  logic              ovf_evt;
  logic              pop;
  logic              last_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [23:0]       fifo_head;

  assign start_acc = i_start && ((state == IDLE) || (state == DONE));
  assign accepting = (state == ARMED) || (state == LOAD);
  // Pixels past the frame size are dropped without flagging an error.
  assign push_try  = i_pix_valid && accepting && (push_cnt < FRAME_CNT);
  assign pop       = o_sram_req && i_sram_grant;
  assign push_ok   = push_try && (!fifo_full || pop);
  assign ovf_evt   = push_try && fifo_full && !pop;
  // An overflowed frame is incomplete and must never report done.
  assign last_wr   = pop && (pix_count == LAST_IDX) && !overflow_r;

  pix_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset || start_acc),
    .push  (push_ok),
    .pop   (pop),
    .din   (i_pix_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)     state_nxt = ARMED;
      ARMED:   if (i_pix_valid) state_nxt = LOAD;
      LOAD:    if (last_wr)     state_nxt = DONE;
      DONE:    if (i_start)     state_nxt = ARMED;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      pix_count  <= '0;
      push_cnt   <= '0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= last_wr;
      if (start_acc) begin
        pix_count  <= '0;
        push_cnt   <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (pop)      pix_count  <= pix_count + 1'b1;
        if (push_try) push_cnt   <= push_cnt + 1'b1;
        if (ovf_evt)  overflow_r <= 1'b1;
      end
    end
  end

  // Address and data are zeroed when idle so every output reads 0 out of reset.
  assign o_sram_req   = (state == LOAD) && !fifo_empty;
  assign o_sram_we    = pop;
  assign o_sram_addr  = o_sram_req ? (BASE_ADDR + pix_count) : '0;
  assign o_sram_wdata = o_sram_req ? rgb888_to_565(fifo_head) : 16'h0000;
  assign o_busy       = accepting;
  assign o_done       = done_r;
  assign o_overflow   = overflow_r;
  assign o_pix_count  = pix_count;

endmodule

// File: tb/tb_image_load_ctrl.sv
// Directed bench: DUT a is a 4x2 frame with an 8-deep FIFO at base 0;
// DUT b is a 2x2 frame with a 2-deep FIFO at base 20'hFFFFE. Both share stimulus.
module tb_image_load_ctrl;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        i_start;
  logic [23:0] i_pix_data;
  logic        i_pix_valid;
  logic        i_sram_grant;

  logic        a_req, a_we, a_busy, a_done, a_ovf;
  logic [19:0] a_addr, a_cnt;
  logic [15:0] a_wdata;
  logic        b_req, b_we, b_busy, b_done, b_ovf;
  logic [19:0] b_addr, b_cnt;
  logic [15:0] b_wdata;

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc_n = 0;
  int  a_last_wr = 0;
  int  b_last_wr = 0;
  int  a_done_cnt = 0;
  int  b_done_cnt = 0;
  int  d0;
  bit  seen;
  bit  hold_chk = 1'b0;
  bit  a_prev_hold = 1'b0;
  logic [19:0] a_prev_addr;
  logic [15:0] a_prev_wdata;
  wr_t a_q[$];
  wr_t b_q[$];

  logic [15:0] t1_exp [8] = '{16'h0000, 16'h0020, 16'h0021, 16'h0041,
                              16'h0041, 16'h0062, 16'h0062, 16'h0883};
  logic [23:0] w_pix  [4] = '{24'h123456, 24'hFFFFFF, 24'h00FC00, 24'h0000F8};
  logic [15:0] w_exp  [4] = '{16'h11AA, 16'hFFFF, 16'h07E0, 16'h001F};
  logic [19:0] w_addr [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc_n <= cyc_n + 1;

  image_load_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(20), .BASE_ADDR(20'h00000), .FIFO_DEPTH(8)) u_a (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .i_start(i_start),
    .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
    .o_sram_req(a_req), .i_sram_grant(i_sram_grant), .o_sram_addr(a_addr),
    .o_sram_wdata(a_wdata), .o_sram_we(a_we), .o_busy(a_busy), .o_done(a_done),
    .o_overflow(a_ovf), .o_pix_count(a_cnt));

  image_load_ctrl #(.IMG_W(2), .IMG_H(2), .ADDR_W(20), .BASE_ADDR(20'hFFFFE), .FIFO_DEPTH(2)) u_b (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .i_start(i_start),
    .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
    .o_sram_req(b_req), .i_sram_grant(i_sram_grant), .o_sram_addr(b_addr),
    .o_sram_wdata(b_wdata), .o_sram_we(b_we), .o_busy(b_busy), .o_done(b_done),
    .o_overflow(b_ovf), .o_pix_count(b_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    cyc();
    cyc();
    reset_reset = 1'b0;
    a_q.delete();
    b_q.delete();
  endtask

  // Write logger plus address/data stability check while a request waits for grant.
  always @(negedge clk_clk) begin
    if (a_we) begin a_q.push_back({a_addr, a_wdata}); a_last_wr = cyc_n; end
    if (b_we) begin b_q.push_back({b_addr, b_wdata}); b_last_wr = cyc_n; end
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (hold_chk && a_prev_hold) begin
      chk("hold_req", a_req, 1);
      chk("hold_addr", a_addr, a_prev_addr);
      chk("hold_wdata", a_wdata, a_prev_wdata);
    end
    a_prev_hold  = a_req && !a_we;
    a_prev_addr  = a_addr;
    a_prev_wdata = a_wdata;
  end

  initial begin
    reset_reset = 1'b1; i_start = 1'b0; i_pix_valid = 1'b0;
    i_pix_data = 24'h0; i_sram_grant = 1'b0;
    cyc(); cyc();
    sample();
    chk("rst_req", a_req, 0);     chk("rst_we", a_we, 0);
    chk("rst_busy", a_busy, 0);   chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);     chk("rst_cnt", a_cnt, 0);
    chk("rst_b_addr", b_addr, 0); chk("rst_b_wdata", b_wdata, 0);
    cyc();
    reset_reset = 1'b0;

    // Back-to-back frame, grant always high.
    i_sram_grant = 1'b1;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    sample();
    chk("t1_busy_armed", a_busy, 1);
    chk("t1_req_armed", a_req, 0);
    for (int k = 1; k <= 8; k++) begin
      i_pix_valid = 1'b1; i_pix_data = 24'(k) * 24'h010203; cyc();
    end
    i_pix_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin sample(); if (a_done) seen = 1'b1; end
    chk("t1_done_seen", seen, 1);
    chk("t1_done_lat", cyc_n - a_last_wr, 1);
    chk("t1_cnt", a_cnt, 8);
    chk("t1_ovf", a_ovf, 0);
    chk("t1_busy_done", a_busy, 0);
    sample();
    chk("t1_done_pulse", a_done, 0);
    chk("t1_cnt_hold", a_cnt, 8);
    chk("t1_nwr", a_q.size(), 8);
    for (int k = 0; k < 8; k++) if (k < a_q.size()) begin
      chk("t1_addr", a_q[k].addr, k);
      chk("t1_data", a_q[k].data, t1_exp[k]);
    end

    // Sparse grant (1 in 3), pixels every 4 cycles.
    a_q.delete(); b_q.delete(); d0 = a_done_cnt;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    hold_chk = 1'b1;
    for (int i = 0; i < 48; i++) begin
      i_sram_grant = (i % 3 == 2);
      i_pix_valid  = (i % 4 == 0) && (i < 32);
      i_pix_data   = 24'((i / 4) + 1) * 24'h010203;
      cyc();
    end
    hold_chk = 1'b0; i_pix_valid = 1'b0;
    sample();
    chk("t2_ovf", a_ovf, 0);
    chk("t2_ndone", a_done_cnt - d0, 1);
    chk("t2_cnt", a_cnt, 8);
    chk("t2_nwr", a_q.size(), 8);
    for (int k = 0; k < 8; k++) if (k < a_q.size()) begin
      chk("t2_addr", a_q[k].addr, k);
      chk("t2_data", a_q[k].data, t1_exp[k]);
    end

    // Overflow on the 2-deep FIFO: grant low for 5 cycles while 4 pixels arrive.
    a_q.delete(); b_q.delete(); d0 = b_done_cnt;
    i_sram_grant = 1'b0;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_pix_valid = 1'b1; i_pix_data = w_pix[0]; cyc();
    i_pix_data = w_pix[1]; cyc();
    sample();
    chk("t3_ovf_full", b_ovf, 0);
    chk("t3_req_wait", b_req, 1);
    chk("t3_we_wait", b_we, 0);
    i_pix_data = w_pix[2]; cyc();
    sample();
    chk("t3_ovf_set", b_ovf, 1);
    i_pix_data = w_pix[3]; cyc();
    i_pix_valid = 1'b0; cyc();
    i_sram_grant = 1'b1;
    repeat (6) cyc();
    sample();
    chk("t3_nwr", b_q.size(), 2);
    if (b_q.size() >= 2) begin
      chk("t3_addr0", b_q[0].addr, 20'hFFFFE); chk("t3_data0", b_q[0].data, 16'h11AA);
      chk("t3_addr1", b_q[1].addr, 20'hFFFFF); chk("t3_data1", b_q[1].data, 16'hFFFF);
    end
    chk("t3_ovf_sticky", b_ovf, 1);
    chk("t3_cnt", b_cnt, 2);
    chk("t3_nodone", b_done_cnt - d0, 0);
    chk("t3_busy", b_busy, 1);

    // Pixels in IDLE are ignored; only the post-start pixel is written.
    do_reset();
    d0 = a_done_cnt;
    i_sram_grant = 1'b1;
    i_pix_valid = 1'b1; i_pix_data = 24'hABCDEF;
    repeat (3) cyc();
    i_pix_valid = 1'b0;
    sample();
    chk("t4_idle_req", a_req, 0);
    chk("t4_idle_busy", a_busy, 0);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_pix_valid = 1'b1; i_pix_data = 24'hFF0000; cyc();
    i_pix_valid = 1'b0;
    repeat (4) cyc();
    sample();
    chk("t4_nwr", a_q.size(), 1);
    if (a_q.size() >= 1) begin
      chk("t4_addr", a_q[0].addr, 0); chk("t4_data", a_q[0].data, 16'hF800);
    end
    chk("t4_b_nwr", b_q.size(), 1);
    if (b_q.size() >= 1) begin
      chk("t4_b_addr", b_q[0].addr, 20'hFFFFE); chk("t4_b_data", b_q[0].data, 16'hF800);
    end
    chk("t4_cnt", a_cnt, 1);
    chk("t4_nodone", a_done_cnt - d0, 0);

    // Reset mid-load after 3 writes.
    do_reset();
    d0 = a_done_cnt;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      i_pix_valid = 1'b1; i_pix_data = 24'(k) * 24'h010203; cyc();
    end
    i_pix_valid = 1'b0; i_sram_grant = 1'b0; reset_reset = 1'b1;
    cyc();
    sample();
    chk("t5_nwr_pre", a_q.size(), 3);
    chk("t5_req", a_req, 0);     chk("t5_we", a_we, 0);
    chk("t5_addr", a_addr, 0);   chk("t5_wdata", a_wdata, 0);
    chk("t5_busy", a_busy, 0);   chk("t5_done", a_done, 0);
    chk("t5_ovf", a_ovf, 0);     chk("t5_cnt", a_cnt, 0);
    chk("t5_b_busy", b_busy, 0); chk("t5_b_cnt", b_cnt, 0);
    chk("t5_nodone", a_done_cnt - d0, 0);
    cyc();
    reset_reset = 1'b0; i_sram_grant = 1'b1;
    a_q.delete(); b_q.delete();
    i_start = 1'b1; cyc(); i_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      i_pix_valid = 1'b1; i_pix_data = 24'(k) * 24'h010203; cyc();
    end
    i_pix_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin sample(); if (a_done) seen = 1'b1; end
    chk("t5_done_seen", seen, 1);
    chk("t5_cnt_after", a_cnt, 8);
    chk("t5_nwr_after", a_q.size(), 8);
    if (a_q.size() >= 1) begin
      chk("t5_addr0", a_q[0].addr, 0); chk("t5_data0", a_q[0].data, t1_exp[0]);
    end

    // Address wrap at the top of the SRAM on DUT b.
    do_reset();
    d0 = b_done_cnt;
    i_sram_grant = 1'b1;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_pix_valid = 1'b1; i_pix_data = w_pix[k]; cyc();
    end
    i_pix_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin sample(); if (b_done) seen = 1'b1; end
    chk("t6_done_seen", seen, 1);
    chk("t6_done_lat", cyc_n - b_last_wr, 1);
    chk("t6_cnt", b_cnt, 4);
    chk("t6_ovf", b_ovf, 0);
    chk("t6_nwr", b_q.size(), 4);
    for (int k = 0; k < 4; k++) if (k < b_q.size()) begin
      chk("t6_addr", b_q[k].addr, w_addr[k]);
      chk("t6_data", b_q[k].data, w_exp[k]);
    end
    sample();
    chk("t6_ndone", b_done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
